// File: rtl/sl_pkg.sv
// Shared types and constants for the SL receiver.
// Line symbols are {zeroes, ones}, both active low.
package sl_pkg;

    localparam int SL_DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_STROBE,
        S_RELEASE
    } sl_state_e;

    localparam int ERR_LEN = 0;
    localparam int ERR_PAR = 1;
    localparam int ERR_TMO = 2;

    localparam logic [1:0] SYM_IDLE = 2'b11;
    localparam logic [1:0] SYM_ZERO = 2'b01;
    localparam logic [1:0] SYM_ONE  = 2'b10;
    localparam logic [1:0] SYM_STOP = 2'b00;

    typedef struct packed {
        logic [2:0]           err;
        logic [SL_DATA_W-1:0] data;
    } sl_entry_t;

endpackage

// File: rtl/sl_rx_fifo_if.sv
// Read-side valid/ready port of the SL receive FIFO.
// master = FIFO side, slave = consumer (APB bridge / DMA).
interface sl_rx_fifo_if
    import sl_pkg::*;
#(
    parameter int DATA_W = SL_DATA_W
);
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [2:0]        rd_err;

    modport master (
        output rd_valid, rd_data, rd_err,
        input  rd_ready
    );

    modport slave (
        input  rd_valid, rd_data, rd_err,
        output rd_ready
    );
endinterface

// File: rtl/sl_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Head word is 0 when empty; ovf pulses when a push is dropped.
module sl_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign do_rd = rd_en & ~empty;
    // A pop in the same cycle frees the slot for a push into a full FIFO
    assign do_wr = wr_en & (~full | do_rd);
    assign ovf   = wr_en & full & ~do_rd;

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sl_rx_fifo.sv
// SL receiver: decodes the two-wire active-low line into words
// with {timeout, parity, length} flags and queues them in a FIFO.
module sl_rx_fifo
    import sl_pkg::*;
#(
    parameter int DATA_W      = SL_DATA_W,
    parameter int FIFO_DEPTH  = 8,
    parameter int STROBE_POS  = 8,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_line_zeroes_a,
    input  logic                          serial_line_ones_a,
    input  logic                          cfg_enable,
    input  logic [5:0]                    cfg_word_len,
    input  logic                          cfg_parity_en,
    sl_rx_fifo_if.master                  rd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_busy,
    output logic                          ovf_flag,
    input  logic                          ovf_clr
);
    localparam int CW = $clog2(TIMEOUT + STROBE_POS + 2);

    logic [SYNC_STAGES-1:0] sync_z;
    logic [SYNC_STAGES-1:0] sync_o;
    logic [1:0]             line;
    logic [1:0]             line_q;
    logic                   fall;

    sl_state_e         state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [CW-1:0]     gap_cnt, gap_n;
    logic [6:0]        bit_cnt, bits_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic              par_acc, par_n;
    logic              word_open, open_n;
    logic [5:0]        len_q, len_n;
    logic              pen_q, pen_n;
    logic              push_q, push_n;
    sl_entry_t         entry_q, entry_n;
    logic [6:0]        exp_bits;
    logic              bit_v;

    sl_entry_t         head;
    logic              fifo_empty;
    logic              fifo_ovf;

    assign line = {sync_z[SYNC_STAGES-1], sync_o[SYNC_STAGES-1]};
    assign fall = |(line_q & ~line);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_z <= '1;
            sync_o <= '1;
            line_q <= SYM_IDLE;
        end else begin
            sync_z <= {sync_z[SYNC_STAGES-2:0], serial_line_zeroes_a};
            sync_o <= {sync_o[SYNC_STAGES-2:0], serial_line_ones_a};
            line_q <= line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            data_q    <= '0;
            par_acc   <= 1'b0;
            word_open <= 1'b0;
            len_q     <= '0;
            pen_q     <= 1'b0;
            push_q    <= 1'b0;
            entry_q   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            gap_cnt   <= gap_n;
            bit_cnt   <= bits_n;
            data_q    <= data_n;
            par_acc   <= par_n;
            word_open <= open_n;
            len_q     <= len_n;
            pen_q     <= pen_n;
            push_q    <= push_n;
            entry_q   <= entry_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        gap_n    = gap_cnt;
        bits_n   = bit_cnt;
        data_n   = data_q;
        par_n    = par_acc;
        open_n   = word_open;
        len_n    = len_q;
        pen_n    = pen_q;
        push_n   = 1'b0;
        entry_n  = '0;
        exp_bits = 7'(len_q) + 7'(pen_q);
        bit_v    = line == SYM_ONE;

        unique case (state)
            S_IDLE: begin
                if (fall) begin
                    state_n = S_STROBE;
                    cnt_n   = '0;
                    gap_n   = '0;
                    bits_n  = '0;
                    data_n  = '0;
                    par_n   = 1'b0;
                    len_n   = cfg_word_len;
                    pen_n   = cfg_parity_en;
                end
            end
            S_GAP: begin
                gap_n = gap_cnt + 1'b1;
                if (fall) begin
                    state_n = S_STROBE;
                    cnt_n   = '0;
                end else if (gap_cnt >= CW'(TIMEOUT)) begin
                    state_n              = S_IDLE;
                    open_n               = 1'b0;
                    push_n               = 1'b1;
                    entry_n.data         = SL_DATA_W'(data_q);
                    entry_n.err[ERR_TMO] = 1'b1;
                end
            end
            S_STROBE: begin
                cnt_n = cnt + 1'b1;
                gap_n = gap_cnt + 1'b1;
                if (line == SYM_IDLE) begin
                    // Pulse too short to be a symbol; gap keeps counting
                    state_n = word_open ? S_GAP : S_IDLE;
                end else if (cnt_n == CW'(STROBE_POS)) begin
                    state_n = S_RELEASE;
                    cnt_n   = '0;
                    if (line == SYM_STOP) begin
                        open_n               = 1'b0;
                        push_n               = 1'b1;
                        entry_n.data         = SL_DATA_W'(data_q);
                        entry_n.err[ERR_LEN] = bit_cnt != exp_bits;
                        entry_n.err[ERR_PAR] = pen_q & ~par_acc;
                    end else begin
                        open_n = 1'b1;
                        for (int i = 0; i < DATA_W; i++) begin
                            if (bit_cnt == 7'(i) && bit_cnt < 7'(len_q))
                                data_n[i] = bit_v;
                        end
                        if (bit_cnt < exp_bits) par_n = par_acc ^ bit_v;
                        if (bit_cnt != '1) bits_n = bit_cnt + 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                if (line == SYM_IDLE) begin
                    state_n = word_open ? S_GAP : S_IDLE;
                    cnt_n   = '0;
                    gap_n   = '0;
                end else if (cnt >= CW'(TIMEOUT)) begin
                    // Stuck low: close the word once, then wait for idle
                    open_n = 1'b0;
                    if (word_open) begin
                        push_n               = 1'b1;
                        entry_n.data         = SL_DATA_W'(data_q);
                        entry_n.err[ERR_TMO] = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (!cfg_enable) begin
            state_n = S_IDLE;
            open_n  = 1'b0;
            push_n  = 1'b0;
        end
    end

    sl_sync_fifo #(
        .WIDTH ($bits(sl_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_q),
        .wr_data (entry_q),
        .rd_en   (rd.rd_ready),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .ovf     (fifo_ovf)
    );

    assign rd.rd_valid = ~fifo_empty;
    assign rd.rd_data  = head.data[DATA_W-1:0];
    assign rd.rd_err   = head.err;
    assign rx_busy     = state != S_IDLE;

    always_ff @(posedge clk) begin
        if (rst)           ovf_flag <= 1'b0;
        else if (fifo_ovf) ovf_flag <= 1'b1;
        else if (ovf_clr)  ovf_flag <= 1'b0;
    end

endmodule

// File: tb/tb_sl_rx_fifo.sv
// Bench for sl_rx_fifo: table of words plus hand-written corner sequences,
// popped entries checked against a scoreboard queue.
module tb_sl_rx_fifo;
    import sl_pkg::*;

    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       zl;
    logic       ol;
    logic       en;
    logic [5:0] wl;
    logic       pen;
    logic       ovf_clr;
    logic [3:0] fifo_count;
    logic       rx_busy;
    logic       ovf_flag;

    sl_rx_fifo_if #(.DATA_W(DW)) rd_if ();

    sl_rx_fifo #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (8),
        .STROBE_POS  (8),
        .TIMEOUT     (255),
        .SYNC_STAGES (2)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .serial_line_zeroes_a (zl),
        .serial_line_ones_a   (ol),
        .cfg_enable           (en),
        .cfg_word_len         (wl),
        .cfg_parity_en        (pen),
        .rd                   (rd_if),
        .fifo_count           (fifo_count),
        .rx_busy              (rx_busy),
        .ovf_flag             (ovf_flag),
        .ovf_clr              (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  err;
        bit          chk_data;
    } exp_t;

    typedef struct {
        int          len;
        bit          p;
        int          nbits;
        logic [63:0] bits;
        logic [31:0] data;
        logic [2:0]  err;
    } vec_t;

    exp_t sb[$];
    vec_t vt[10];
    int   checks   = 0;
    int   failures = 0;
    int   rise;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rd_if.rd_valid && rd_if.rd_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop actual=%0h required=none",
                         rd_if.rd_data);
            end else begin
                e = sb.pop_front();
                if (e.chk_data) chk("pop_data", 64'(rd_if.rd_data), 64'(e.data));
                chk("pop_err", 64'(rd_if.rd_err), 64'(e.err));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic [1:0] s, input int n);
        {zl, ol} = s;
        repeat (n) tick();
    endtask

    task automatic send_bits(input int nbits, input logic [63:0] bits,
                             input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            sym(bits[i] ? SYM_ONE : SYM_ZERO, 16);
            if (i == glitch_at) begin
                sym(SYM_IDLE, 6);
                sym(SYM_ONE, 4);
                sym(SYM_IDLE, 6);
            end else begin
                sym(SYM_IDLE, 16);
            end
        end
    endtask

    // rise: ticks from the stop falling edge until rd_valid first goes high
    task automatic send_word(input int len, input bit p, input int nbits,
                             input logic [63:0] bits, input int glitch_at,
                             input int pop_edge, output int rise_o);
        logic was;
        wl = 6'(len);
        pen = p;
        send_bits(nbits, bits, glitch_at);
        was = rd_if.rd_valid;
        rise_o = 0;
        {zl, ol} = SYM_STOP;
        for (int k = 1; k <= 16; k++) begin
            if (k == pop_edge) rd_if.rd_ready = 1'b1;
            tick();
            if (k == pop_edge) rd_if.rd_ready = 1'b0;
            if (rise_o == 0 && !was && rd_if.rd_valid) rise_o = k;
        end
        sym(SYM_IDLE, 16);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [2:0] e,
                               input bit cd);
        exp_t x;
        x.data = d;
        x.err = e;
        x.chk_data = cd;
        sb.push_back(x);
    endtask

    task automatic drain();
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
        tick();
        chk("drain_left", 64'(sb.size()), 64'd0);
        chk("drain_count", 64'(fifo_count), 64'd0);
    endtask

    initial begin
        vt[0] = '{8,  1'b0, 8,  64'hA5,          32'hA5,       3'b000};
        vt[1] = '{32, 1'b1, 33, 64'h1_DEADBEEF,  32'hDEADBEEF, 3'b000};
        vt[2] = '{32, 1'b1, 33, 64'h0_DEADBEEF,  32'hDEADBEEF, 3'b010};
        vt[3] = '{16, 1'b0, 12, 64'hABC,         32'hABC,      3'b001};
        vt[4] = '{8,  1'b0, 0,  64'h0,           32'h0,        3'b001};
        vt[5] = '{8,  1'b0, 10, 64'h3FF,         32'hFF,       3'b001};
        vt[6] = '{8,  1'b1, 9,  64'h0F3,         32'hF3,       3'b010};
        vt[7] = '{8,  1'b1, 9,  64'h1F3,         32'hF3,       3'b000};
        vt[8] = '{8,  1'b1, 11, 64'h7F3,         32'hF3,       3'b001};
        vt[9] = '{12, 1'b0, 12, 64'h800,         32'h800,      3'b000};

        rst = 1'b1;
        {zl, ol} = SYM_IDLE;
        en = 1'b1;
        wl = 6'd8;
        pen = 1'b0;
        ovf_clr = 1'b0;
        rd_if.rd_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(rd_if.rd_valid), 64'd0);
        chk("rst_data", 64'(rd_if.rd_data), 64'd0);
        chk("rst_err", 64'(rd_if.rd_err), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_busy", 64'(rx_busy), 64'd0);
        chk("rst_ovf", 64'(ovf_flag), 64'd0);
        rst = 1'b0;
        repeat (4) tick();

        // stop-to-valid latency
        expect_word(32'hA5, 3'b000, 1'b1);
        send_word(8, 1'b0, 8, 64'hA5, -1, 0, rise);
        chk("latency", 64'(rise), 64'd12);
        drain();

        // table of words
        rd_if.rd_ready = 1'b1;
        for (int v = 0; v < 10; v++) begin
            expect_word(vt[v].data, vt[v].err, 1'b1);
            send_word(vt[v].len, vt[v].p, vt[v].nbits, vt[v].bits, -1, 0, rise);
        end
        drain();

        // short low glitch on the ones line inside a word
        expect_word(32'h3C, 3'b000, 1'b1);
        send_word(8, 1'b0, 8, 64'h3C, 2, 0, rise);
        drain();

        // gap timeout after 4 bits
        wl = 6'd16;
        pen = 1'b0;
        expect_word(32'h0, 3'b100, 1'b0);
        send_bits(4, 64'hA, -1);
        chk("tmo_busy_mid", 64'(rx_busy), 64'd1);
        sym(SYM_IDLE, 300);
        chk("tmo_busy_end", 64'(rx_busy), 64'd0);
        drain();

        // overflow: fill, drop a 9th, then push+pop while full
        rd_if.rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_word(32'h10 + 32'(i), 3'b000, 1'b1);
            send_word(8, 1'b0, 8, 64'h10 + 64'(i), -1, 0, rise);
        end
        send_word(8, 1'b0, 8, 64'h99, -1, 0, rise);
        chk("ovf_count", 64'(fifo_count), 64'd8);
        chk("ovf_flag_set", 64'(ovf_flag), 64'd1);
        chk("ovf_head", 64'(rd_if.rd_data), 64'h10);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_flag_clr", 64'(ovf_flag), 64'd0);
        expect_word(32'hAA, 3'b000, 1'b1);
        send_word(8, 1'b0, 8, 64'hAA, -1, 12, rise);
        chk("full_pushpop_count", 64'(fifo_count), 64'd8);
        chk("full_pushpop_ovf", 64'(ovf_flag), 64'd0);
        drain();

        // disable mid-word: silent abort, then a normal word
        rd_if.rd_ready = 1'b0;
        wl = 6'd8;
        send_bits(5, 64'h15, -1);
        en = 1'b0;
        sym(SYM_IDLE, 4);
        chk("abort_busy", 64'(rx_busy), 64'd0);
        sym(SYM_IDLE, 300);
        chk("abort_count", 64'(fifo_count), 64'd0);
        en = 1'b1;
        rd_if.rd_ready = 1'b1;
        expect_word(32'h96, 3'b000, 1'b1);
        send_word(8, 1'b0, 8, 64'h96, -1, 0, rise);
        drain();

        // reset with entries queued
        rd_if.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_word(8, 1'b0, 8, 64'h40 + 64'(i), -1, 0, rise);
        chk("pre_rst_count", 64'(fifo_count), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", 64'(rd_if.rd_valid), 64'd0);
        chk("post_rst_count", 64'(fifo_count), 64'd0);
        chk("post_rst_data", 64'(rd_if.rd_data), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sl_rx_fifo.md
Name: sl_rx_fifo

Overview:
Parametrised next-generation serial-line (SL) receiver. Decodes the two-wire, active-low SL protocol (zeroes line / ones line) into words of configurable length with optional parity. Runs fully in the 16 MHz core domain and buffers decoded words plus per-word error flags in an internal FIFO. The FIFO is drained through a valid/ready port by the APB bridge or DMA layer.

Parameters:
DATA_W, 32, max word width; cfg_word_len ranges 8..DATA_W
FIFO_DEPTH, 8, entries (power of two, >=2)
STROBE_POS, 8, cycles after a detected falling edge at which the line is sampled
TIMEOUT, 255, max cycles allowed for a gap mid-word or for a line held low before abort
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
clk  in  1  core clock, 16 MHz
rst  in  1  synchronous, active-high reset
serial_line_zeroes_a  in  1  async SL zeroes line, idle high
serial_line_ones_a  in  1  async SL ones line, idle high
cfg_enable  in  1  receiver enable; 0 forces IDLE, no new words
cfg_word_len  in  6  data bits per word (8..DATA_W)
cfg_parity_en  in  1  1 = one odd-parity bit follows the data bits
rd_valid  out  1  FIFO not empty
rd_ready  in  1  consumer pop strobe (pop when rd_valid & rd_ready)
rd_data  out  DATA_W  head word, right-aligned; 0 when empty
rd_err  out  3  head flags {timeout, parity, length}; 0 when empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
rx_busy  out  1  word reception in progress
ovf_flag  out  1  sticky: a word was dropped because the FIFO was full
ovf_clr  in  1  clears ovf_flag

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM IDLE; synchronisers preset to 1 (idle line).
- Protocol: each symbol is exactly one line low. Zeroes line low = bit 0; ones line low = bit 1; both low = stop. Symbols are separated by both-high gaps. Data is sent LSB first, so bit i lands at rd_data[i]. Upper bits above cfg_word_len are 0.
- cfg_word_len and cfg_parity_en are latched at the first falling edge of a word and held until that word ends.
- FSM GAP (IDLE when no word is open): count both-high cycles.
  - Falling edge on either synced line -> STROBE, cnt=0, rx_busy=1.
  - Word open and gap cnt reaches TIMEOUT -> push entry with timeout flag, go IDLE.
- STROBE: cnt increments.
  - Both lines high before cnt==STROBE_POS -> glitch; discard, return to GAP; the gap count continues.
  - At cnt==STROBE_POS, sample:
    - Single line low -> accept bit, go RELEASE. Data bits beyond the latched length and beyond the parity bit are counted but not stored.
    - Both low -> stop; push entry, go RELEASE.
- RELEASE: wait until both lines are high, then go GAP.
  - Low for more than TIMEOUT cycles -> push timeout entry if a word is open, then go IDLE once both lines are high.
- Length flag: set when received bit count != word_len + parity_en. A stop with zero bits pushes an entry with the length flag set.
- Parity flag (parity_en=1 only): set when the total number of ones over data bits plus the parity bit is even.
- Push timing: entry written on the cycle after the stop sample; rd_valid rises the following cycle. End-to-end from line edge = SYNC_STAGES + STROBE_POS + 2 cycles.
- FIFO is first-word-fall-through, with independent read and write pointers.
  - Push when full without a same-cycle pop -> word dropped, ovf_flag=1.
  - Push and pop in the same cycle when full -> both succeed.
  - Pop when empty -> ignored.
  - ovf_flag set and ovf_clr in the same cycle -> set wins.
- cfg_enable=0 mid-word -> abort silently (no push), go IDLE. FIFO contents are kept.
- rst mid-word -> partial word discarded, FIFO flushed.

Decomposition:
- Package sl_pkg holds:
  - FSM state encoding (IDLE, GAP, STROBE, RELEASE)
  - error bit indices (ERR_LEN=0, ERR_PAR=1, ERR_TMO=2)
  - FIFO entry struct {err[2:0], data[DATA_W-1:0]}
  - symbol constants
- Sub-module sl_sync_fifo: a generic synchronous FWFT FIFO (width, depth). It provides count, full/empty, and overflow detection.

Test Plan:
- Send word_len=8, parity off, data 0xA5 as bits LSB first (16 cycles low, 16 high each), then stop -> rd_data=0x000000A5, rd_err=0, rd_valid rises 12 cycles after the stop falling edge.
- Send word_len=32, parity on, 0xDEADBEEF plus correct parity bit 1 (24 ones, so parity bit makes the total odd) -> rd_data=0xDEADBEEF, rd_err=0. Repeat with parity bit 0 -> rd_err=3'b010.
- Send word_len=16 but only 12 bits, then stop -> rd_err=3'b001. Send 4 bits, then hold a 300-cycle gap -> entry with rd_err=3'b100, rx_busy falls.
- Apply a 4-cycle low glitch on the ones line within a word (STROBE_POS=8) -> ignored; the word decodes correctly.
- Fill the FIFO with 8 words, rd_ready=0, send a 9th -> fifo_count=8, ovf_flag=1, the first word is still at the head. Pop and push in the same cycle while full -> count stays 8, no overflow.
- Drive cfg_enable low after 5 bits -> no entry pushed. Re-enable and send a full word -> it decodes normally. Assert rst with 3 entries queued -> rd_valid=0, fifo_count=0.
